// File: rtl/reg_file_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_wb_if
// Description : Read, write-back and debug-dump signal bundle for reg_file_wb.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_wb_if #(
    parameter int WIDTH = 32
);
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             ovf;
    logic             ovf_flag;
    logic             dump_start;
    logic             dump_busy;
    logic             dump_valid;
    logic             dump_ready;
    logic [4:0]       dump_addr;
    logic [WIDTH-1:0] dump_data;

    modport master (
        output rs_addr, rt_addr, wr_en, wr_addr, wr_data, ovf, dump_start, dump_ready,
        input  rd_data1, rd_data2, ovf_flag, dump_busy, dump_valid, dump_addr, dump_data
    );

    modport slave (
        input  rs_addr, rt_addr, wr_en, wr_addr, wr_data, ovf, dump_start, dump_ready,
        output rd_data1, rd_data2, ovf_flag, dump_busy, dump_valid, dump_addr, dump_data
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_wb
// Description : 32x32 MIPS register file with overflow-suppressed write-back
//               and a valid/ready register dump port.
//               Optional macro REGFILE_BYPASS_EN enables read write-through.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_wb #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] SP_RESET = '0
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    reg_file_wb_if.slave  bus
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_SEND     = 1'b1;
    localparam int         c_SP_INDEX = 29;
    localparam logic [4:0] c_LAST     = 5'd31;

    logic [WIDTH-1:0] r_regs [0:31];
    logic             r_ovf_flag;
    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [4:0]       r_dump_addr;
    logic [4:0]       w_dump_addr_next;
    logic             w_dump_valid;
    logic             w_dump_busy;
    logic             w_wr_commit;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    assign w_wr_commit = bus.wr_en && !bus.ovf && (bus.wr_addr != 5'd0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i[4:0]] <= (i == c_SP_INDEX) ? SP_RESET : '0;
            end
        end else if (w_wr_commit) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf_flag <= 1'b0;
        end else if (bus.wr_en && bus.ovf) begin
            r_ovf_flag <= 1'b1;
        end
    end

    always_comb begin
        w_rd1 = (bus.rs_addr == 5'd0) ? '0 : r_regs[bus.rs_addr];
        w_rd2 = (bus.rt_addr == 5'd0) ? '0 : r_regs[bus.rt_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_commit && (bus.rs_addr == bus.wr_addr)) w_rd1 = bus.wr_data;
        if (w_wr_commit && (bus.rt_addr == bus.wr_addr)) w_rd2 = bus.wr_data;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= c_IDLE;
            r_dump_addr <= 5'd0;
        end else begin
            r_state     <= w_state_next;
            r_dump_addr <= w_dump_addr_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_dump_addr_next = r_dump_addr;
        w_dump_valid     = 1'b0;
        w_dump_busy      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.dump_start) begin
                    w_state_next     = c_SEND;
                    w_dump_addr_next = 5'd0;
                end
            end
            c_SEND: begin
                w_dump_valid = 1'b1;
                w_dump_busy  = 1'b1;
                if (bus.dump_ready) begin
                    if (r_dump_addr == c_LAST) begin
                        w_state_next     = c_IDLE;
                        w_dump_addr_next = 5'd0;
                    end else begin
                        w_dump_addr_next = r_dump_addr + 5'd1;
                    end
                end
            end
            default: begin
                w_state_next     = c_IDLE;
                w_dump_addr_next = 5'd0;
            end
        endcase
    end

    assign bus.rd_data1   = w_rd1;
    assign bus.rd_data2   = w_rd2;
    assign bus.ovf_flag   = r_ovf_flag;
    assign bus.dump_valid = w_dump_valid;
    assign bus.dump_busy  = w_dump_busy;
    assign bus.dump_addr  = r_dump_addr;
    // The dump always sees stored contents; write-through never reaches it.
    assign bus.dump_data  = (r_dump_addr == 5'd0) ? '0 : r_regs[r_dump_addr];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_wb
// Description : Self-checking bench for reg_file_wb against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_wb;

    localparam logic [31:0] c_SP = 32'h0000_7FF0;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    reg_file_wb_if bus ();

    reg_file_wb #(.WIDTH(32), .SP_RESET(c_SP)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model of the architectural state.
    logic [31:0] m_regs [32];
    logic        m_flag;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        ovf;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic        exp_flag;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_regs[29] = c_SP;
        m_flag     = 1'b0;
    endtask

    task automatic model_edge();
        if (bus.wr_en) begin
            if (bus.ovf) m_flag = 1'b1;
            else if (bus.wr_addr != 5'd0) m_regs[bus.wr_addr] = bus.wr_data;
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'h0 : m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (bus.wr_en && !bus.ovf && bus.wr_addr != 5'd0 && a == bus.wr_addr) v = bus.wr_data;
`endif
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en      = 1'b0;
        bus.wr_addr    = 5'd0;
        bus.wr_data    = 32'h0;
        bus.ovf        = 1'b0;
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        #12;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.ovf = 1'b0;
        step();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int cycles;
        int valid_cnt;
        logic [31:0] old3;

        checks = 0;
        errors = 0;
        RST    = 1'b0;
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd0;
        idle_inputs();
        model_reset();
        #3;
        do_reset();

        // Reset state over both read ports.
        for (int i = 0; i < 32; i++) begin
            bus.rs_addr = 5'(i);
            bus.rt_addr = 5'(31 - i);
            #1;
            chk($sformatf("reset_rs%0d", i), bus.rd_data1, (i == 29) ? c_SP : 32'h0);
            chk($sformatf("reset_rt%0d", 31 - i), bus.rd_data2, (31 - i == 29) ? c_SP : 32'h0);
        end
        chk("reset_ovf_flag", 32'(bus.ovf_flag), 32'h0);
        chk("reset_dump_valid", 32'(bus.dump_valid), 32'h0);
        chk("reset_dump_busy", 32'(bus.dump_busy), 32'h0);
        chk("reset_dump_addr", 32'(bus.dump_addr), 32'h0);

        // Directed vectors: write on an edge, then read after it.
        vecs[0] = '{1'b1, 5'd8,  32'hDEAD_BEEF, 1'b0, 5'd8,  5'd0,  32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1] = '{1'b1, 5'd0,  32'h0000_1234, 1'b0, 5'd0,  5'd8,  32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 5'd9,  32'h0000_0005, 1'b0, 5'd9,  5'd29, 32'h5,         c_SP,          1'b0};
        vecs[3] = '{1'b1, 5'd9,  32'h7FFF_FFFF, 1'b1, 5'd9,  5'd8,  32'h5,         32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{1'b0, 5'd10, 32'h0000_FFFF, 1'b1, 5'd10, 5'd9,  32'h0,         32'h5,         1'b1};
        vecs[5] = '{1'b1, 5'd31, 32'hCAFE_F00D, 1'b0, 5'd31, 5'd29, 32'hCAFE_F00D, c_SP,          1'b1};
        for (int v = 0; v < 6; v++) begin
            bus.wr_en = vecs[v].wr_en; bus.wr_addr = vecs[v].wr_addr;
            bus.wr_data = vecs[v].wr_data; bus.ovf = vecs[v].ovf;
            step();
            idle_inputs();
            bus.rs_addr = vecs[v].rs;
            bus.rt_addr = vecs[v].rt;
            #1;
            chk($sformatf("vec%0d_rd1", v), bus.rd_data1, vecs[v].exp1);
            chk($sformatf("vec%0d_rd2", v), bus.rd_data2, vecs[v].exp2);
            chk($sformatf("vec%0d_flag", v), 32'(bus.ovf_flag), 32'(vecs[v].exp_flag));
        end
        do_reset();
        #1;
        chk("flag_cleared_by_rst", 32'(bus.ovf_flag), 32'h0);

        // Same-cycle read/write of $3.
        write_reg(5'd3, 32'h1111_2222);
        old3 = m_regs[3];
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hA5A5_A5A5; bus.ovf = 1'b0;
        bus.rs_addr = 5'd3; bus.rt_addr = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same_cycle", bus.rd_data1, 32'hA5A5_A5A5);
`else
        chk("nobypass_same_cycle", bus.rd_data1, old3);
`endif
        chk("rt_same_cycle", bus.rd_data2, exp_read(5'd3));
        step();
        bus.wr_en = 1'b0;
        #1;
        chk("bypass_next_cycle", bus.rd_data1, 32'hA5A5_A5A5);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bus.wr_en   = 1'($urandom_range(0, 3) != 0);
            bus.wr_addr = 5'($urandom_range(0, 31));
            bus.wr_data = $urandom;
            bus.ovf     = 1'($urandom_range(0, 39) == 0);
            bus.rs_addr = ($urandom_range(0, 3) == 0) ? bus.wr_addr : 5'($urandom_range(0, 31));
            bus.rt_addr = 5'($urandom_range(0, 31));
            #1;
            chk($sformatf("rand%0d_rd1", n), bus.rd_data1, exp_read(bus.rs_addr));
            chk($sformatf("rand%0d_rd2", n), bus.rd_data2, exp_read(bus.rt_addr));
            chk($sformatf("rand%0d_flag", n), 32'(bus.ovf_flag), 32'(m_flag));
            step();
        end
        idle_inputs();

        // Dump with toggling ready, a mid-dump write and an ignored dump_start.
        do_reset();
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i * 4));
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        chk("dump_first_valid", 32'(bus.dump_valid), 32'h1);
        chk("dump_first_addr", 32'(bus.dump_addr), 32'h0);
        beats  = 0;
        cycles = 0;
        while (beats < 32 && cycles < 200) begin
            bus.dump_ready = cycles[0];
            bus.dump_start = (cycles == 9);
            bus.wr_en      = (cycles == 4);
            bus.wr_addr    = 5'd20;
            bus.wr_data    = 32'h0000_1111;
            #1;
            chk($sformatf("dump_c%0d_valid", cycles), 32'(bus.dump_valid), 32'h1);
            chk($sformatf("dump_c%0d_addr", cycles), 32'(bus.dump_addr), 32'(beats));
            if (bus.dump_ready) begin
                chk($sformatf("dump_beat%0d_data", beats), bus.dump_data,
                    (beats == 0) ? 32'h0 : m_regs[beats]);
                beats++;
            end
            step();
            cycles++;
        end
        idle_inputs();
        chk("dump_beat_count", 32'(beats), 32'd32);
        chk("dump_busy_after", 32'(bus.dump_busy), 32'h0);
        chk("dump_valid_after", 32'(bus.dump_valid), 32'h0);
        chk("dump_addr_after", 32'(bus.dump_addr), 32'h0);

        // Full-rate dump: exactly 32 valid cycles.
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b1;
        valid_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.dump_valid) valid_cnt++;
            step();
        end
        bus.dump_ready = 1'b0;
        chk("fullrate_valid_cycles", 32'(valid_cnt), 32'd32);

        // Reset mid-dump after beat 10.
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b1;
        for (int c = 0; c < 11; c++) step();
        chk("pre_rst_addr", 32'(bus.dump_addr), 32'd11);
        RST = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_valid", 32'(bus.dump_valid), 32'h0);
        chk("rst_mid_busy", 32'(bus.dump_busy), 32'h0);
        chk("rst_mid_addr", 32'(bus.dump_addr), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        valid_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.dump_valid) valid_cnt++;
            step();
        end
        chk("post_rst_no_beats", 32'(valid_cnt), 32'd0);
        bus.rs_addr = 5'd29;
        bus.rt_addr = 5'd5;
        #1;
        chk("post_rst_sp", bus.rd_data1, c_SP);
        chk("post_rst_r5", bus.rd_data2, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_wb.md
# reg_file_wb

32×32-bit MIPS general-purpose register file for the single-cycle CPU. It sits directly upstream of the ALU: its two read ports drive ALU operands A and B. It also takes the write-back result and the ALU overflow flag from the same stage, and exposes a sequential debug dump port that streams every register out over a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32, register data width (only 32 is supported)
- SP_RESET, 32'h0000_0000, value loaded into register 29 ($sp) on reset

Ports:
- CLK  input  1  system clock; all state changes on its rising edge
- RST  input  1  asynchronous, active-high reset
- rs_addr  input  5  read port 1 address
- rt_addr  input  5  read port 2 address
- rd_data1  output  32  contents of rs_addr; drives ALU A
- rd_data2  output  32  contents of rt_addr; drives ALU B
- wr_en  input  1  write-back enable
- wr_addr  input  5  write-back destination
- wr_data  input  32  write-back value (ALU result or memory data)
- ovf  input  1  ALU overflow for the instruction being written back
- ovf_flag  output  1  sticky overflow-suppressed-write indicator
- dump_start  input  1  one-cycle request to start a register dump
- dump_busy  output  1  dump in progress
- dump_valid  output  1  dump beat valid
- dump_ready  input  1  consumer accepts beat
- dump_addr  output  5  register index of current beat
- dump_data  output  32  register contents of current beat

## Operation
- Read ports are combinational. An address of 0 always returns 32'h0.
- Write is committed at the CLK rising edge only when wr_en=1, wr_addr≠0 and ovf=0.
- A write with wr_addr=0 is discarded silently.
- A write with wr_en=1 and ovf=1 is discarded and sets ovf_flag=1.
- ovf_flag stays set until RST. ovf is ignored when wr_en=0.
- Dump FSM states are IDLE and SEND:
  - IDLE→SEND when dump_start=1. dump_addr is loaded with 0.
  - In SEND: dump_valid=1, dump_busy=1, and dump_data is the live value of register dump_addr (register 0 reads as 0).
  - A handshake is dump_valid=1 and dump_ready=1. On each handshake, dump_addr increments.
  - A handshake with dump_addr=31 returns the FSM to IDLE (dump_addr back to 0).
  - dump_start is ignored while in SEND.
- Writes proceed normally during a dump. A beat reflects register contents in the cycle that beat is accepted.
- Reset values: registers 1–31 are 0 except register 29, which is SP_RESET. ovf_flag=0, dump_busy=0, dump_valid=0, dump_addr=0, FSM=IDLE.
- RST asserted mid-dump aborts the dump immediately. All outputs take their reset values, and no further beats are produced.

## Timing
- Read latency is 0 cycles (combinational from address to data).
- Write latency is 1 cycle: data is readable in the cycle after the edge that committed it.
- dump_start sampled at edge N gives dump_valid=1 with dump_addr=0 from edge N onward.
- With dump_ready held at 1, there are 32 consecutive beats and dump_valid is high for exactly 32 cycles.
- dump_busy=0 immediately after the edge that accepts beat 31.
- dump_ready=0 stalls the dump: dump_addr holds and dump_valid stays 1.
- Same-cycle read and write to the same address: see Configuration.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: if wr_en=1, ovf=0, wr_addr≠0, and rs_addr or rt_addr equals wr_addr, the matching read port returns wr_data in the same cycle (write-through).
- Not defined: read ports return the pre-write register value in that cycle. The new value appears after the edge.
- The bypass does not apply to the dump port in either case.

## Test plan
- Reset: pulse RST, then read all 32 addresses. Expect 0 everywhere, $29 = SP_RESET, ovf_flag=0, dump_valid=0.
- Write/read: write 32'hDEAD_BEEF to $8, then read rs=8, rt=0. Expect rd_data1=32'hDEAD_BEEF and rd_data2=0. A write of 32'h1234 to $0 still reads 0.
- Overflow suppression: $9=32'h5, then wr_en=1 to $9 with 32'h7FFF_FFFF and ovf=1. Expect $9 still reads 32'h5 and ovf_flag=1 until RST.
- Bypass: write 32'hA5A5_A5A5 to $3 with rs=3 in the same cycle.
  - With REGFILE_BYPASS_EN: rd_data1=32'hA5A5_A5A5 that cycle.
  - Without it: old value that cycle, new value the next cycle.
- Dump with backpressure: registers hold value = index×4. Pulse dump_start with dump_ready toggling every cycle. Expect 32 beats with addr 0..31 and data 0,4,…,124 (beat 0 data 0). dump_busy falls after beat 31, and a dump_start mid-dump is ignored.
- Reset mid-dump: assert RST after beat 10. Expect dump_valid=0 and dump_busy=0 immediately, and no further beats after RST is released.
